// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// Build option: define MDU_CANCEL_EN to add the cancel port that aborts an in-flight operation.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic               state_r;
  logic [CW-1:0]      cnt_r;
  logic [31:0]        hi_r;
  logic [31:0]        lo_r;
  logic [31:0]        pend_hi_r;
  logic [31:0]        pend_lo_r;
  logic               pend_wr_r;

  logic               cancel_s;
  logic               accept_s;
  logic               last_s;
  logic               commit_s;
  logic signed [63:0] sa_ext_s;
  logic signed [63:0] sb_ext_s;
  logic signed [63:0] sprod_s;
  logic [63:0]        ua_ext_s;
  logic [63:0]        ub_ext_s;
  logic [63:0]        uprod_s;
  logic               div_zero_s;
  logic               div_ovf_s;
  logic [31:0]        divisor_s;
  logic signed [31:0] squot_s;
  logic signed [31:0] srem_s;
  logic [31:0]        uquot_s;
  logic [31:0]        urem_s;
  logic [31:0]        res_hi_s;
  logic [31:0]        res_lo_s;
  logic               res_wr_s;
  logic [CW-1:0]      load_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  assign accept_s = start && (state_r == ST_IDLE) && !cancel_s;
  assign last_s   = (cnt_r == CNT_ONE);
  assign commit_s = (state_r == ST_BUSY) && last_s && !cancel_s && pend_wr_r;

  assign sa_ext_s = {{32{a[31]}}, a};
  assign sb_ext_s = {{32{b[31]}}, b};
  assign ua_ext_s = {32'd0, a};
  assign ub_ext_s = {32'd0, b};
  assign sprod_s  = sa_ext_s * sb_ext_s;
  assign uprod_s  = ua_ext_s * ub_ext_s;

  // The divider never sees 0 or the overflowing -1 case; those results are selected explicitly.
  assign div_zero_s = (b == 32'd0);
  assign div_ovf_s  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign divisor_s  = (div_zero_s || div_ovf_s) ? 32'd1 : b;
  assign squot_s    = $signed(a) / $signed(divisor_s);
  assign srem_s     = $signed(a) % $signed(divisor_s);
  assign uquot_s    = a / divisor_s;
  assign urem_s     = a % divisor_s;

  // Result and latency selection for the operation presented this cycle.
  always_comb begin
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    res_wr_s = 1'b0;
    load_s   = CNT_ZERO;
    case (op)
      OP_MULT: begin
        res_hi_s = sprod_s[63:32];
        res_lo_s = sprod_s[31:0];
        res_wr_s = 1'b1;
        load_s   = MULT_LOAD;
      end
      OP_MULTU: begin
        res_hi_s = uprod_s[63:32];
        res_lo_s = uprod_s[31:0];
        res_wr_s = 1'b1;
        load_s   = MULT_LOAD;
      end
      OP_DIV: begin
        if (div_ovf_s) begin
          res_hi_s = 32'd0;
          res_lo_s = 32'h8000_0000;
        end else begin
          res_hi_s = srem_s;
          res_lo_s = squot_s;
        end
        res_wr_s = !div_zero_s;
        load_s   = DIV_LOAD;
      end
      OP_DIVU: begin
        res_hi_s = urem_s;
        res_lo_s = uquot_s;
        res_wr_s = !div_zero_s;
        load_s   = DIV_LOAD;
      end
      default: begin
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        res_wr_s = 1'b0;
        load_s   = CNT_ZERO;
      end
    endcase
  end

  // Operation sequencing: accept, count down, then leave busy on commit or cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (load_s != CNT_ZERO)) begin
            state_r   <= ST_BUSY;
            cnt_r     <= load_s;
            pend_hi_r <= res_hi_s;
            pend_lo_r <= res_lo_s;
            pend_wr_r <= res_wr_s;
          end
        end
        ST_BUSY: begin
          if (cancel_s || last_s) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Architectural HI/LO: written only at a commit edge or by MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (commit_s) begin
      hi_r <= pend_hi_r;
      lo_r <= pend_lo_r;
    end else if (accept_s) begin
      case (op)
        OP_MTHI: hi_r <= a;
        OP_MTLO: lo_r <= a;
        default: begin
          hi_r <= hi_r;
          lo_r <= lo_r;
        end
      endcase
    end
  end

  assign busy = state_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, hand sequences and random ops against an arithmetic HI/LO model.
// Define MDU_CANCEL_EN to include the cancel sequences.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[13];

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: what HI/LO become once an operation completes, by plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] mop, input logic [31:0] xa, input logic [31:0] xb,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] nh, output logic [31:0] nl);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ua = {32'd0, xa};
    ub = {32'd0, xb};
    nh = h;
    nl = l;
    case (mop)
      3'd0: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; end
      3'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; end
      3'd2: if (xb != 32'd0) begin sq = sa / sb; sr = sa % sb; nl = sq[31:0]; nh = sr[31:0]; end
      3'd3: if (xb != 32'd0) begin uq = ua / ub; ur = ua % ub; nl = uq[31:0]; nh = ur[31:0]; end
      3'd4: nh = xa;
      3'd5: nl = xa;
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] mop);
    if (mop == 3'd0 || mop == 3'd1) return MC;
    if (mop == 3'd2 || mop == 3'd3) return DC;
    return 0;
  endfunction

  // Called at a negedge: issue one op, follow it through busy, check the committed HI/LO.
  task automatic run_op(input logic [2:0] xop, input logic [31:0] xa, input logic [31:0] xb, input bit intrude);
    logic [31:0] nh, nl;
    int n;
    model(xop, xa, xb, exp_hi, exp_lo, nh, nl);
    n = latency(xop);
    start = 1'b1; op = xop; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("busy_during", {31'd0, busy}, 32'd1);
      chk("hi_held", hi, exp_hi);
      chk("lo_held", lo, exp_lo);
      if (intrude && k == 0) begin
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_result", hi, nh);
    chk("lo_result", lo, nl);
    exp_hi = nh;
    exp_lo = nl;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif

    tbl[0]  = '{3'd0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{3'd3, 32'd7,         32'd2,        32'd1,         32'd3};
    tbl[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    tbl[5]  = '{3'd4, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'h8000_0000};
    tbl[6]  = '{3'd5, 32'h9ABC_DEF0, 32'd0,        32'h1234_5678, 32'h9ABC_DEF0};
    tbl[7]  = '{3'd3, 32'd5,         32'd0,        32'h1234_5678, 32'h9ABC_DEF0};
    tbl[8]  = '{3'd6, 32'hDEAD_BEEF, 32'd1,        32'h1234_5678, 32'h9ABC_DEF0};
    tbl[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    tbl[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    tbl[11] = '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    tbl[12] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0};

    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
      chk("tbl_hi", hi, tbl[i].hi);
      chk("tbl_lo", lo, tbl[i].lo);
    end

    // Start while a DIV is busy is ignored; the next MULT goes in right after busy falls.
    run_op(3'd2, 32'd100, 32'd7, 1'b1);
    chk("intrude_hi", hi, 32'd2);
    chk("intrude_lo", lo, 32'd14);
    run_op(3'd0, 32'd3, 32'hFFFF_FFFC, 1'b0);
    chk("b2b_hi", hi, 32'hFFFF_FFFF);
    chk("b2b_lo", lo, 32'hFFFF_FFF4);

    // Asynchronous reset in cycle 4 of a DIV clears everything and nothing commits later.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_nocommit_busy", {31'd0, busy}, 32'd0);
    chk("rst_nocommit_hi", hi, 32'd0);
    chk("rst_nocommit_lo", lo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;

    for (int r = 0; r < 40; r++) begin
      logic [31:0] rb;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), $urandom, rb, 1'b0);
    end

`ifdef MDU_CANCEL_EN
    // Cancel mid-MULT, cancel on the commit edge, and cancel racing an idle start.
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("cancel_hi", hi, exp_hi);
    chk("cancel_lo", lo, exp_lo);

    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (MC - 1) @(negedge clk);
    chk("cancel_last_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_last_busy2", {31'd0, busy}, 32'd0);
    chk("cancel_last_hi", hi, exp_hi);
    chk("cancel_last_lo", lo, exp_lo);

    cancel = 1'b1; start = 1'b1; op = 3'd4; a = ~exp_hi;
    @(negedge clk);
    chk("cancel_mthi_hi", hi, exp_hi);
    op = 3'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    chk("cancel_start_busy", {31'd0, busy}, 32'd0);
    cancel = 1'b0; start = 1'b0;
    repeat (MC + 1) @(negedge clk);
    chk("cancel_start_hi", hi, exp_hi);
    chk("cancel_start_lo", lo, exp_lo);
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
